// File: rtl/ddram_cache.sv
// Per-channel single-line read cache in front of a 64-bit DDRAM port.
// Reads allocate whole lines. Writes go straight through to DDRAM and also patch a line that hits.
module ddram_cache #(
    parameter int          CHANNELS   = 4,
    parameter int          LINE_BEATS = 2,
    parameter logic [3:0]  DDR_BASE   = 4'b0011,
    localparam int         CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [27:1]     mem_addr,
    input  logic [31:0]     mem_din,
    input  logic [3:0]      mem_be,
    input  logic            mem_16b,
    input  logic [CH_W-1:0] mem_chan,
    input  logic            mem_flush,
    output logic [31:0]     mem_dout,
    output logic            mem_ack,
    output logic            mem_busy,
    output logic            DDRAM_CLK,
    input  logic            DDRAM_BUSY,
    output logic [7:0]      DDRAM_BURSTCNT,
    output logic [28:0]     DDRAM_ADDR,
    input  logic [63:0]     DDRAM_DOUT,
    input  logic            DDRAM_DOUT_READY,
    output logic            DDRAM_RD,
    output logic [63:0]     DDRAM_DIN,
    output logic [7:0]      DDRAM_BE,
    output logic            DDRAM_WE
);

    localparam int          LB_LOG    = $clog2(LINE_BEATS);
    localparam int          BEAT_W    = (LINE_BEATS > 1) ? LB_LOG : 1;
    localparam int          TAG_W     = 25 - LB_LOG;
    localparam int          LINE_W    = LINE_BEATS * 64;
    localparam logic [24:0] BEAT_MASK = 25'(LINE_BEATS - 1);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_FILL, WR_ISSUE} state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [CHANNELS-1:0] valid;
    logic [TAG_W-1:0]    tag [CHANNELS];
    logic [LINE_W-1:0]   line_data [CHANNELS];

    logic [CH_W-1:0]     req_chan;
    logic [BEAT_W-1:0]   req_beat;
    logic [1:0]          req_hw;
    logic                req_16b;
    logic [TAG_W-1:0]    req_tag;
    logic                flush_seen;

    logic [TAG_W-1:0]    addr_tag;
    logic [BEAT_W-1:0]   addr_beat;
    logic [24:0]         line_qaddr;
    logic                accept;
    logic                hit;
    logic                write_hit;
    logic                fill_beat;
    logic                fill_last;
    logic [63:0]         hit_beat;
    logic [7:0]          wr_be;
    logic [63:0]         wr_data;
    logic [LINE_W-1:0]   fill_line;
    logic [31:0]         fill_dout;

    // Big-endian lane pick: addr[2:1]=00 is the top halfword, addr[2]=0 the top longword.
    function automatic logic [31:0] lane_select(input logic [63:0] beat,
                                                input logic [1:0]  hw,
                                                input logic        is16);
        logic [31:0] r;
        if (is16) begin
            case (hw)
                2'd0:    r = {16'h0000, beat[63:48]};
                2'd1:    r = {16'h0000, beat[47:32]};
                2'd2:    r = {16'h0000, beat[31:16]};
                default: r = {16'h0000, beat[15:0]};
            endcase
        end else begin
            r = hw[1] ? beat[31:0] : beat[63:32];
        end
        return r;
    endfunction

    assign DDRAM_CLK  = clk;
    assign addr_tag   = mem_addr[27:3+LB_LOG];
    assign addr_beat  = BEAT_W'(mem_addr[27:3] & BEAT_MASK);
    assign line_qaddr = mem_addr[27:3] & ~BEAT_MASK;
    assign accept     = (state == IDLE) && mem_req;
    assign hit        = valid[mem_chan] && (tag[mem_chan] == addr_tag);
    assign write_hit  = accept && mem_we && hit;
    assign fill_beat  = (state == RD_FILL) && DDRAM_DOUT_READY;
    assign fill_last  = fill_beat && (beat_cnt == BEAT_W'(LINE_BEATS - 1));
    assign hit_beat   = line_data[mem_chan][addr_beat*64 +: 64];

    always_comb begin
        wr_data = {2{mem_din}};
        wr_be   = mem_addr[2] ? {4'b0000, mem_be} : {mem_be, 4'b0000};
        if (mem_16b) begin
            wr_data = {4{mem_din[15:0]}};
            case (mem_addr[2:1])
                2'd0:    wr_be = {mem_be[1:0], 6'b000000};
                2'd1:    wr_be = {2'b00, mem_be[1:0], 4'b0000};
                2'd2:    wr_be = {4'b0000, mem_be[1:0], 2'b00};
                default: wr_be = {6'b000000, mem_be[1:0]};
            endcase
        end
    end

    // The last beat is merged in here so the requested word can be returned in the same edge.
    always_comb begin
        fill_line = line_data[req_chan];
        fill_line[beat_cnt*64 +: 64] = DDRAM_DOUT;
        fill_dout = lane_select(fill_line[req_beat*64 +: 64], req_hw, req_16b);
    end

    always_ff @(posedge clk) begin
        if (write_hit) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_be[i])
                    line_data[mem_chan][addr_beat*64 + i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
        if (fill_beat)
            line_data[req_chan][beat_cnt*64 +: 64] <= DDRAM_DOUT;
        if (fill_last)
            tag[req_chan] <= req_tag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            valid          <= '0;
            mem_ack        <= 1'b0;
            mem_busy       <= 1'b0;
            mem_dout       <= '0;
            DDRAM_RD       <= 1'b0;
            DDRAM_WE       <= 1'b0;
            DDRAM_BURSTCNT <= '0;
            DDRAM_ADDR     <= '0;
            DDRAM_DIN      <= '0;
            DDRAM_BE       <= '0;
            req_chan       <= '0;
            req_beat       <= '0;
            req_hw         <= '0;
            req_16b        <= 1'b0;
            req_tag        <= '0;
            flush_seen     <= 1'b0;
        end else begin
            mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        req_chan   <= mem_chan;
                        req_beat   <= addr_beat;
                        req_hw     <= mem_addr[2:1];
                        req_16b    <= mem_16b;
                        req_tag    <= addr_tag;
                        flush_seen <= 1'b0;
                        if (mem_we) begin
                            state          <= WR_ISSUE;
                            mem_busy       <= 1'b1;
                            DDRAM_WE       <= 1'b1;
                            DDRAM_BURSTCNT <= 8'd1;
                            DDRAM_ADDR     <= {DDR_BASE, mem_addr[27:3]};
                            DDRAM_DIN      <= wr_data;
                            DDRAM_BE       <= wr_be;
                        end else if (hit) begin
                            mem_dout <= lane_select(hit_beat, mem_addr[2:1], mem_16b);
                            mem_ack  <= 1'b1;
                        end else begin
                            state          <= RD_ISSUE;
                            mem_busy       <= 1'b1;
                            DDRAM_RD       <= 1'b1;
                            DDRAM_BURSTCNT <= 8'(LINE_BEATS);
                            DDRAM_BE       <= 8'hFF;
                            DDRAM_ADDR     <= {DDR_BASE, line_qaddr};
                        end
                    end
                end
                RD_ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        beat_cnt <= '0;
                        state    <= RD_FILL;
                    end
                end
                RD_FILL: begin
                    if (DDRAM_DOUT_READY) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (fill_last) begin
                            if (!flush_seen)
                                valid[req_chan] <= 1'b1;
                            mem_dout <= fill_dout;
                            mem_ack  <= 1'b1;
                            mem_busy <= 1'b0;
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                WR_ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_WE <= 1'b0;
                        mem_ack  <= 1'b1;
                        mem_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A flush seen while a miss is outstanding poisons the line being filled.
            if (mem_flush) begin
                valid <= '0;
                if (state != IDLE)
                    flush_seen <= 1'b1;
            end
        end
    end

endmodule
